// File: rtl/muldiv_sched_if.sv
// Command/result bundle between the main controller and the HI/LO multiply/divide sequencer.
interface muldiv_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mf_req,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mf_req,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide sequencer: computes the result on acceptance and retires it into
// HI/LO after a fixed latency, holding busy/stall meanwhile.
module muldiv_sched #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_sched_if.slave  bus
);
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = ($clog2(MAX_LAT + 1) < 4) ? 4 : $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [63:0]   pending;
    logic          skip;
    logic [31:0]   hi_r, lo_r;
    logic          done_r;

    logic          is_long, is_div, accept;
    logic [63:0]   result;
    logic [31:0]   ua, ub, ub_safe, uq, ur;
    logic          a_neg, b_neg;

    assign is_long = (bus.op[2] == 1'b0);
    assign is_div  = is_long && bus.op[1];
    assign accept  = (state == IDLE) && bus.start;

    // Signed divide via magnitudes: sidesteps the 0x80000000/-1 overflow and gives
    // truncation toward zero with the remainder following the dividend's sign.
    always_comb begin
        a_neg   = (bus.op == 3'b010) && bus.a[31];
        b_neg   = (bus.op == 3'b010) && bus.b[31];
        ua      = a_neg ? (32'd0 - bus.a) : bus.a;
        ub      = b_neg ? (32'd0 - bus.b) : bus.b;
        ub_safe = (ub == '0) ? 32'd1 : ub;
        uq      = ua / ub_safe;
        ur      = ua % ub_safe;
        result  = '0;
        case (bus.op)
            3'b000:  result = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
            3'b001:  result = {32'd0, bus.a} * {32'd0, bus.b};
            3'b010,
            3'b011:  result = {(a_neg ? (32'd0 - ur) : ur),
                               ((a_neg ^ b_neg) ? (32'd0 - uq) : uq)};
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start && is_long) state_next = RUN;
            RUN:     if (cnt == CW'(1))        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state == RUN);
        bus.stall = bus.busy && (bus.mf_req || bus.start);
        bus.done  = done_r;
        bus.hi    = hi_r;
        bus.lo    = lo_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r    <= '0;
            lo_r    <= '0;
            pending <= '0;
            skip    <= 1'b0;
            cnt     <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                case (bus.op)
                    3'b000, 3'b001: begin
                        pending <= result;
                        skip    <= 1'b0;
                        cnt     <= CW'(MUL_LAT);
                    end
                    3'b010, 3'b011: begin
                        pending <= result;
                        skip    <= (bus.b == '0);
                        cnt     <= CW'(DIV_LAT);
                    end
                    3'b100:  hi_r <= bus.a;
                    3'b101:  lo_r <= bus.a;
                    default: ;
                endcase
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    if (!skip) {hi_r, lo_r} <= pending;
                    done_r <= 1'b1;
                end
            end
        end
    end

    logic unused;
    assign unused = is_div;
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: latency, results, MTHI/MTLO, divide-by-zero, stall, reset abort.
module tb_muldiv_sched;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    muldiv_sched_if bus ();

    muldiv_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(lat));
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        tick();
        chk({tag, "_done_clear"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0; bus.mf_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);

        run_op("mult", 3'b000, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", 3'b001, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("divu", 3'b011, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negb", 3'b010, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

        // MTHI / MTLO take effect at the accepting edge
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h11;
        tick();
        chk("mthi_hi", 64'(bus.hi), 64'h11);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        bus.op = 3'b101; bus.a = 32'h22;
        tick();
        bus.start = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h22);
        chk("mtlo_done", 64'(bus.done), 64'd0);

        run_op("div0", 3'b010, 32'd1234, 32'd0, 10, 32'h11, 32'h22);

        // reserved op is ignored
        bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h99; bus.b = 32'h1;
        tick();
        bus.start = 1'b0;
        chk("rsv_busy", 64'(bus.busy), 64'd0);
        chk("rsv_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});

        // stall during DIV with mf_req held, plus an ignored start while busy
        bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd3;
        tick();
        bus.start = 1'b0; bus.mf_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_busy", 64'(bus.stall), 64'd1);
            if (i == 0) chk("hold_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});
            if (i == 3) begin
                bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd2; bus.b = 32'd3;
            end
            if (i == 5) bus.start = 1'b0;
            tick();
        end
        chk("stall_after", 64'(bus.stall), 64'd0);
        chk("stall_busy_after", 64'(bus.busy), 64'd0);
        chk("stall_done", 64'(bus.done), 64'd1);
        chk("stall_hilo", {bus.hi, bus.lo}, {32'd1, 32'd33});
        bus.mf_req = 1'b0;
        tick();
        chk("stall_no_queue", 64'(bus.busy), 64'd0);

        // reset mid-MULT aborts without update or done
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd4;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_done", 64'(bus.done), 64'd0);
        end
        run_op("mult_after", 3'b000, 32'd6, 32'd7, 5, 32'd0, 32'd42);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
